// File: rtl/mat_pkg.sv
// Shared definitions for the matrix-vector datapath and its output stages.
package mat_pkg;

    // Default vector length and element width, shared with mat_mul.
    localparam int N_DEFAULT = 16;
    localparam int W_DEFAULT = 16;

    // Serializer control states.
    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_t;

    // One result element at the default width.
    typedef logic signed [W_DEFAULT-1:0] elem_t;

endpackage

// File: rtl/vec_act.sv
// Per-element activation: arithmetic right shift followed by an optional ReLU.
// Purely combinational so it can sit on any capture path.
module vec_act #(
    parameter int W     = 16,
    parameter int SHIFT = 0,
    parameter bit RELU  = 1'b1
) (
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    logic signed [W-1:0] shifted;

    // Sign-extending shift rounds toward minus infinity and never needs extra width.
    assign shifted = x >>> SHIFT;

    // Clamp negatives to zero only when the rectifier is enabled.
    assign y = (RELU && shifted[W-1]) ? '0 : shifted;

endmodule

// File: rtl/vec_act_serializer.sv
// Captures one N-element result vector in a single handshake, applies the
// activation to every element on the way in, then streams the elements out
// one per cycle over valid/ready.
module vec_act_serializer
    import mat_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int W     = W_DEFAULT,
    parameter int SHIFT = 0,
    parameter bit RELU  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  in_vec [N],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 busy
);

    localparam int               IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    ser_state_t          state;
    ser_state_t          state_next;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_next;
    logic signed [W-1:0] act_vec [N];
    logic signed [W-1:0] buffer  [N];
    logic                capture;

    // One activation unit per element so the whole vector is processed on the capture edge.
    for (genvar i = 0; i < N; i++) begin : g_act
        vec_act #(
            .W     (W),
            .SHIFT (SHIFT),
            .RELU  (RELU)
        ) u_act (
            .x (in_vec[i]),
            .y (act_vec[i])
        );
    end

    // A vector is taken only while idle; in_valid during streaming is ignored.
    assign capture = (state == IDLE) && in_valid;

    // State and index registers; reset drops any buffered vector.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state and index sequencing: advance one element per accepted beat.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = STREAM;
                    idx_next   = '0;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Element buffer, written with already-activated values on the capture edge.
    always_ff @(posedge clk) begin
        // NOTE: no reset on the buffer; it is only read after a capture has filled it.
        if (capture) begin
            buffer <= act_vec;
        end
    end

    // Outputs decode registered state only; out_ready never reaches in_ready combinationally.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == STREAM);
        busy      = (state == STREAM);
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        if (state == STREAM) begin
            out_data = buffer[idx];
            out_idx  = idx;
            out_last = (idx == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_vec_act_serializer.sv
// Bench for vec_act_serializer: three instances (ReLU, pass-through, shift by 2)
// share one stimulus stream and are scored against a queue-based model.
module tb_vec_act_serializer;

    localparam int N    = 16;
    localparam int W    = 16;
    localparam int NCFG = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic                        out_ready;
    logic signed [W-1:0]         in_vec [N];
    logic [NCFG-1:0]             in_ready;
    logic [NCFG-1:0]             out_valid;
    logic [NCFG-1:0]             out_last;
    logic [NCFG-1:0]             busy;
    logic [NCFG-1:0][W-1:0]      out_data;
    logic [NCFG-1:0][3:0]        out_idx;

    typedef struct packed {
        logic [NCFG-1:0][W-1:0] d;
        logic [3:0]             idx;
        logic                   last;
    } beat_t;

    beat_t exp_q [$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    always #5 clk = ~clk;

    vec_act_serializer #(.N(N), .W(W), .SHIFT(0), .RELU(1'b1)) dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_vec(in_vec), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_idx(out_idx[0]), .out_last(out_last[0]),
        .busy(busy[0])
    );

    vec_act_serializer #(.N(N), .W(W), .SHIFT(0), .RELU(1'b0)) dut_pass (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_vec(in_vec), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_idx(out_idx[1]), .out_last(out_last[1]),
        .busy(busy[1])
    );

    vec_act_serializer #(.N(N), .W(W), .SHIFT(2), .RELU(1'b0)) dut_shift (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_vec(in_vec), .out_valid(out_valid[2]), .out_ready(out_ready),
        .out_data(out_data[2]), .out_idx(out_idx[2]), .out_last(out_last[2]),
        .busy(busy[2])
    );

    function automatic int cfg_shift(int k);
        return (k == 2) ? 2 : 0;
    endfunction

    function automatic bit cfg_relu(int k);
        return (k == 0);
    endfunction

    // Reference activation: floor division by 2**sh, then optional clamp.
    function automatic logic [W-1:0] act_ref(int x, int sh, bit relu);
        int div;
        int y;
        div = 1 << sh;
        if (x >= 0) y = x / div;
        else        y = -((-x + div - 1) / div);
        if (relu && y < 0) y = 0;
        return y[W-1:0];
    endfunction

    // Model: the queue holds beats still owed to the consumer; empty means ready.
    function automatic void model_edge();
        beat_t b;
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (in_valid) begin
                for (int i = 0; i < N; i++) begin
                    for (int k = 0; k < NCFG; k++)
                        b.d[k] = act_ref(int'(in_vec[i]), cfg_shift(k), cfg_relu(k));
                    b.idx  = 4'(i);
                    b.last = (i == N - 1);
                    exp_q.push_back(b);
                end
            end
        end else if (out_ready) begin
            void'(exp_q.pop_front());
        end
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drives n cycles and scores every output of every instance against the model.
    // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    // in_mode: 0 hold inputs, 1 random valid and data, 2 valid high with random data.
    task automatic run_cycles(int n, int ready_mode, int in_mode);
        logic [NCFG-1:0][W-1:0] held_d;
        logic [NCFG-1:0][3:0]   held_i;
        bit                     stalled;
        bit                     ev;
        beat_t                  fb;
        stalled = 1'b0;
        held_d  = '0;
        held_i  = '0;
        for (int c = 0; c < n; c++) begin
            if (in_mode != 0) begin
                in_valid = (in_mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
                for (int i = 0; i < N; i++) in_vec[i] = W'($urandom);
            end
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ev = (exp_q.size() != 0);
            fb = ev ? exp_q[0] : '0;
            for (int k = 0; k < NCFG; k++) begin
                total++;
                if (out_valid[k] !== ev) begin
                    bad++;
                    $display("FAIL out_valid cfg=%0d cyc=%0d got=%b want=%b", k, cyc, out_valid[k], ev);
                end
                total++;
                if (in_ready[k] !== !ev) begin
                    bad++;
                    $display("FAIL in_ready cfg=%0d cyc=%0d got=%b want=%b", k, cyc, in_ready[k], !ev);
                end
                total++;
                if (busy[k] !== ev) begin
                    bad++;
                    $display("FAIL busy cfg=%0d cyc=%0d got=%b want=%b", k, cyc, busy[k], ev);
                end
                total++;
                if (out_data[k] !== fb.d[k]) begin
                    bad++;
                    $display("FAIL out_data cfg=%0d cyc=%0d got=%0d want=%0d", k, cyc,
                             $signed(out_data[k]), $signed(fb.d[k]));
                end
                total++;
                if (out_idx[k] !== fb.idx) begin
                    bad++;
                    $display("FAIL out_idx cfg=%0d cyc=%0d got=%0d want=%0d", k, cyc, out_idx[k], fb.idx);
                end
                total++;
                if (out_last[k] !== fb.last) begin
                    bad++;
                    $display("FAIL out_last cfg=%0d cyc=%0d got=%b want=%b", k, cyc, out_last[k], fb.last);
                end
            end
            if (stalled) begin
                total++;
                if (out_data !== held_d || out_idx !== held_i) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d got_idx=%0d want_idx=%0d", cyc, out_idx[0], held_i[0]);
                end
            end
            stalled = out_valid[0] && !out_ready;
            held_d  = out_data;
            held_i  = out_idx;
            tick();
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_vec[i] = '0;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 3'b111 || out_valid !== 3'b000 || busy !== 3'b000 || out_last !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl got_ready=%b got_valid=%b got_busy=%b got_last=%b want=111/000/000/000",
                     in_ready, out_valid, busy, out_last);
        end
        total++;
        if (out_data !== '0 || out_idx !== '0) begin
            bad++;
            $display("FAIL reset_data got_data=%h got_idx=%h want=0", out_data, out_idx);
        end
    endtask

    task automatic test_zero_vector();
        for (int i = 0; i < N; i++) in_vec[i] = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        run_cycles(N + 2, 0, 0);
        total++;
        if (in_ready !== 3'b111) begin
            bad++;
            $display("FAIL zero_ready_after got=%b want=111", in_ready);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < N; i++) in_vec[i] = W'(i - 8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run_cycles(N + 2, 0, 0);
    endtask

    task automatic test_shift_edge();
        for (int i = 0; i < N; i++) in_vec[i] = W'($urandom);
        in_vec[0] = -16'sd5;
        in_vec[1] = 16'sd32767;
        in_vec[2] = -16'sd32768;
        in_vec[3] = -16'sd1;
        in_vec[4] = 16'sd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        total++;
        if (out_data[2] !== 16'hfffe) begin
            bad++;
            $display("FAIL shift_first got=%0d want=-2", $signed(out_data[2]));
        end
        run_cycles(N + 2, 0, 0);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < N; i++) in_vec[i] = W'($urandom);
        in_valid = 1'b1;
        tick();
        for (int i = 0; i < N; i++) in_vec[i] = W'($urandom);
        run_cycles(N + 4, 1, 0);
        for (int i = 0; i < N; i++) in_vec[i] = W'($urandom);
        run_cycles(2 * N + 4, 1, 0);
        in_valid = 1'b0;
        run_cycles(3 * N + 4, 1, 0);
    endtask

    task automatic test_back_to_back();
        run_cycles(3 * (N + 1), 0, 2);
        in_valid = 1'b0;
        run_cycles(N + 2, 0, 0);
    endtask

    task automatic test_reset_mid_stream();
        bit found;
        for (int i = 0; i < N; i++) in_vec[i] = W'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        found    = 1'b0;
        for (int c = 0; c < 4 * N; c++) begin
            if (out_valid[0] && out_idx[0] == 4'd5) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reach_idx5 got=timeout want=out_idx 5");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (out_valid !== 3'b000 || busy !== 3'b000 || in_ready !== 3'b111) begin
            bad++;
            $display("FAIL midreset got_valid=%b got_busy=%b got_ready=%b want=000/000/111",
                     out_valid, busy, in_ready);
        end
        for (int i = 0; i < N; i++) in_vec[i] = 16'sd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        run_cycles(N + 2, 0, 0);
    endtask

    task automatic test_random();
        run_cycles(400, 2, 1);
        in_valid = 1'b0;
        run_cycles(3 * N + 4, 1, 0);
    endtask

    initial begin
        test_reset();
        test_zero_vector();
        test_ramp();
        test_shift_edge();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
